// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants, state type and helpers for the multi-channel clock divider
package clk_div_pkg;

    localparam int DEF_DIV_W = 32;
    localparam int DEF_DIV   = 40;
    localparam int MIN_DIV   = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_t;

    // Number of high cycles in a period of d: ceil(d/2). Wide so any DIV_W up to 64 fits.
    function automatic logic [63:0] half_hi(input logic [63:0] d);
        return d - (d >> 1);
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// rtl/clk_div_channel.sv - one divider channel: run state, counter, double-buffered divisor, registered outputs
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = DEF_DIV_W,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_div_we,
    input  logic [DIV_W-1:0] i_div_wdata,
    output logic             o_clk,
    output logic             o_tick
);

    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] MIN_D   = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    ch_state_t        state, state_n;
    logic [DIV_W-1:0] cnt, cnt_n;
    logic [DIV_W-1:0] d, d_n;
    logic [DIV_W-1:0] s;
    logic [DIV_W-1:0] eff_s;
    logic [63:0]      hh;
    logic             clk_n, tick_n;

    assign eff_s = i_div_we ? i_div_wdata : s;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            d      <= RST_DIV;
            s      <= RST_DIV;
            o_clk  <= 1'b0;
            o_tick <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            d      <= d_n;
            o_clk  <= clk_n;
            o_tick <= tick_n;
            if (i_div_we) begin
                s <= i_div_wdata;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        d_n     = d;
        clk_n   = 1'b0;
        tick_n  = 1'b0;
        hh      = '0;

        // Every period boundary (start, sync, degenerate divisor, wrap) reloads D from the shadow.
        if (!i_en) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else if (state == ST_IDLE || i_sync || d < MIN_D || cnt == d - ONE) begin
            state_n = ST_RUN;
            cnt_n   = '0;
            d_n     = eff_s;
        end else begin
            cnt_n = cnt + ONE;
        end

        // Outputs come from next-state values so the registers line up with cnt.
        hh = half_hi(64'(d_n));
        if (state_n == ST_RUN) begin
            if (d_n < MIN_D) begin
                tick_n = 1'b1;
            end else begin
                clk_n  = (cnt_n < hh[DIV_W-1:0]);
                tick_n = (cnt_n == d_n - ONE);
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - NUM_CH independent programmable clock dividers with shared sync and write data
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = DEF_DIV_W,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NUM_CH-1:0] i_en,
    input  logic              i_sync,
    input  logic [NUM_CH-1:0] i_div_we,
    input  logic [DIV_W-1:0]  i_div_wdata,
    output logic [NUM_CH-1:0] o_clk,
    output logic [NUM_CH-1:0] o_tick
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        clk_div_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_en        (i_en[c]),
            .i_sync      (i_sync),
            .i_div_we    (i_div_we[c]),
            .i_div_wdata (i_div_wdata),
            .o_clk       (o_clk[c]),
            .o_tick      (o_tick[c])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - scoreboard bench for clk_div_multi with directed divisor, sync, disable and reset vectors
module tb_clk_div_multi;

    logic        i_clk;
    logic        i_rst;
    logic [3:0]  i_en;
    logic        i_sync;
    logic [3:0]  i_div_we;
    logic [31:0] i_div_wdata;
    logic [3:0]  o_clk;
    logic [3:0]  o_tick;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] mask;
        logic [3:0] eclk;
        logic [3:0] etick;
        string      name;
    } exp_t;

    exp_t q[$];

    clk_div_multi #(
        .NUM_CH      (4),
        .DIV_W       (32),
        .DEFAULT_DIV (40)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_sync      (i_sync),
        .i_div_we    (i_div_we),
        .i_div_wdata (i_div_wdata),
        .o_clk       (o_clk),
        .o_tick      (o_tick)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Hand formula for a period of d at phase k: high for ceil(d/2) cycles, tick on the last.
    function automatic logic pclk(input int d, input int k);
        return k < d - d / 2;
    endfunction

    function automatic logic ptick(input int d, input int k);
        return k == d - 1;
    endfunction

    function automatic logic [3:0] bit_at(input int c, input logic b);
        return {3'b000, b} << c;
    endfunction

    // Queue the expected outputs for the cycle after the coming edge, then advance one cycle.
    task automatic step(input logic [3:0] mask, input logic [3:0] eclk,
                        input logic [3:0] etick, input string name);
        exp_t e;
        e.mask  = mask;
        e.eclk  = eclk;
        e.etick = etick;
        e.name  = name;
        q.push_back(e);
        @(negedge i_clk);
        i_div_we = '0;
        i_sync   = 1'b0;
    endtask

    task automatic chk(input int c, input int d, input int k, input string name);
        step(bit_at(c, 1'b1), bit_at(c, pclk(d, k)), bit_at(c, ptick(d, k)), name);
    endtask

    task automatic chk2(input int k2, input int k3, input string name);
        step(4'b1100, bit_at(2, pclk(6, k2)) | bit_at(3, pclk(10, k3)),
             bit_at(2, ptick(6, k2)) | bit_at(3, ptick(10, k3)), name);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.mask != 4'b0000) begin
                    total++;
                    if ((((o_clk ^ e.eclk) & e.mask) != 4'b0000) ||
                        (((o_tick ^ e.etick) & e.mask) != 4'b0000)) begin
                        bad++;
                        $display("FAIL %s @%0t: clk=%b tick=%b required clk=%b tick=%b (mask %b)",
                                 e.name, $time, o_clk, o_tick, e.eclk, e.etick, e.mask);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        i_rst       = 1'b1;
        i_en        = 4'b0000;
        i_sync      = 1'b0;
        i_div_we    = 4'b0000;
        i_div_wdata = '0;
        @(negedge i_clk);
        step(4'hF, 4'h0, 4'h0, "reset");
        step(4'hF, 4'h0, 4'h0, "reset");
        i_rst = 1'b0;
        step(4'hF, 4'h0, 4'h0, "idle");

        i_en[0] = 1'b1;
        for (int k = 0; k < 80; k++) chk(0, 40, k % 40, "div40 default");
        i_en[0] = 1'b0;
        step(4'h1, 4'h0, 4'h0, "ch0 off");

        i_div_we = 4'b0010; i_div_wdata = 32'd5;
        step(4'h2, 4'h0, 4'h0, "ch1 idle write");
        i_en[1] = 1'b1;
        for (int k = 0; k < 15; k++) chk(1, 5, k % 5, "div5");
        i_en[1] = 1'b0;
        step(4'h2, 4'h0, 4'h0, "ch1 off");

        i_div_we = 4'b0100; i_div_wdata = 32'd8;
        step(4'h4, 4'h0, 4'h0, "ch2 idle write");
        i_en[2] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                i_div_we = 4'b0100; i_div_wdata = 32'd3;
            end
            chk(2, 8, k, "div8 midwrite");
        end
        for (int k = 0; k < 6; k++) chk(2, 3, k % 3, "div3 after boundary");
        for (int k = 0; k < 12; k++) begin
            if (k == 0) begin
                i_div_we = 4'b0100; i_div_wdata = 32'd6;
            end
            chk(2, 6, k % 6, "div6 wrap bypass");
        end

        i_div_we = 4'b1000; i_div_wdata = 32'd1;
        step(4'h8, 4'h0, 4'h0, "ch3 idle write");
        i_en[3] = 1'b1;
        for (int k = 0; k < 4; k++) step(4'h8, 4'h0, 4'h8, "div1");
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin
                i_div_we = 4'b1000; i_div_wdata = 32'd0;
            end
            step(4'h8, 4'h0, 4'h8, "div0");
        end
        for (int k = 0; k < 9; k++) begin
            if (k == 0) begin
                i_div_we = 4'b1000; i_div_wdata = 32'd4;
            end
            chk(3, 4, k % 4, "div4 after degenerate");
        end

        i_en[3:2] = 2'b00;
        step(4'hC, 4'h0, 4'h0, "ch2 ch3 off");
        i_div_we = 4'b1000; i_div_wdata = 32'd10;
        step(4'hC, 4'h0, 4'h0, "ch3 write10");
        i_en[2] = 1'b1;
        for (int k = 0; k < 3; k++) chk(2, 6, k, "ch2 pre-sync");
        i_en[3] = 1'b1;
        for (int j = 0; j < 4; j++) chk2((3 + j) % 6, j, "out of phase");
        i_sync = 1'b1;
        chk2(0, 0, "sync phase0");
        for (int k = 1; k < 7; k++) chk2(k % 6, k % 10, "post-sync aligned");
        chk(2, 6, 1, "ch2 high before disable");
        i_en[2] = 1'b0;
        step(4'h4, 4'h0, 4'h0, "ch2 disable mid-high");
        i_en[2] = 1'b1;
        for (int k = 0; k < 7; k++) chk(2, 6, k % 6, "ch2 re-enable");

        i_en = 4'b0000;
        step(4'hF, 4'h0, 4'h0, "all off");
        i_div_we = 4'b0010; i_div_wdata = 32'd7;
        step(4'h2, 4'h0, 4'h0, "ch1 write7");
        i_en[1] = 1'b1;
        for (int k = 0; k < 4; k++) chk(1, 7, k, "div7");
        i_rst = 1'b1; i_en = 4'b0000;
        step(4'hF, 4'h0, 4'h0, "reset mid-run");
        i_rst = 1'b0;
        step(4'hF, 4'h0, 4'h0, "after reset");
        i_en[1] = 1'b1;
        for (int k = 0; k < 41; k++) chk(1, 40, k % 40, "default after reset");

        @(posedge i_clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel programmable clock divider and tick generator for the FPGA top level. Each of `NUM_CH` channels divides the system clock by a runtime-programmable integer. Each channel produces a registered near-50%-duty divided clock and a one-cycle tick enable. Divisor updates are double-buffered and take effect only at a period boundary. A shared sync input phase-aligns all channels. It replaces the fixed divide-by-40 toggler used for display/debug clocks and adds slow-peripheral strobes.

## Interface
Parameters:
- `NUM_CH`, 4, number of independent channels.
- `DIV_W`, 32, divisor width in bits.
- `DEFAULT_DIV`, 40, divisor loaded into every channel at reset.

Ports:
- `i_clk`  input  1  system clock; all logic on rising edge.
- `i_rst`  input  1  synchronous, active-high reset.
- `i_en`  input  NUM_CH  per-channel run enable.
- `i_sync`  input  1  one-cycle pulse; restarts all active channels at phase 0.
- `i_div_we`  input  NUM_CH  per-channel shadow-divisor write strobe.
- `i_div_wdata`  input  DIV_W  divisor value, shared by all write strobes.
- `o_clk`  output  NUM_CH  registered divided clock per channel.
- `o_tick`  output  NUM_CH  registered one-cycle strobe in the last cycle of each period.

## Operation
Per-channel state:
- `active` flag.
- Counter `cnt` (DIV_W bits).
- Active divisor `D`.
- Shadow divisor `S`.

Reset:
- `active`=0, `cnt`=0.
- `D`=`S`=`DEFAULT_DIV`.
- `o_clk`=0, `o_tick`=0.

Shadow write:
- At any edge with `i_div_we[c]`=1, `S` takes `i_div_wdata`.
- `D` is never written directly.

States are IDLE (`active`=0) and RUN (`active`=1).
- IDLE → RUN: edge samples `i_en[c]`=1. `cnt`←0 and `D`←effective `S`.
- RUN → IDLE: edge samples `i_en[c]`=0. `cnt`←0, and `o_clk` and `o_tick` go 0 on that edge.
- In RUN, `cnt` increments each cycle.
- At wrap (`cnt`==`D`−1), `cnt`←0 and `D`←effective `S` (boundary load).

Effective `S` means: if `i_div_we[c]` is asserted on the same edge, use `i_div_wdata` (write bypass). Otherwise use `S`.

`i_sync`:
- On an edge with `i_sync`=1, every channel in RUN does `cnt`←0 and `D`←effective `S`.
- Priority, highest first: `i_rst` > `i_en` deassert > `i_sync` > wrap > increment.

Outputs are registered and derived from next-state values, so they align with `cnt`:
- `o_clk`=1 while `cnt` < `D`−⌊`D`/2⌋, else 0. High for ⌈`D`/2⌉ cycles and low for ⌊`D`/2⌋ cycles.
- `o_tick`=1 when `cnt`==`D`−1.

Degenerate divisor (`D`<2, i.e. 0 or 1):
- `o_tick`=1 every RUN cycle.
- `o_clk` held 0.
- `cnt` held 0; every edge counts as a boundary, so a new `S` applies on the next edge.

Arithmetic:
- Comparisons are unsigned DIV_W-bit.
- `cnt` never exceeds `D`−1, so no overflow occurs.
- `D`=2^DIV_W−1 is legal.

## Timing
- Latency from enable:
  - The edge sampling `i_en`=1 starts the period.
  - In the following cycle `cnt`=0 and `o_clk`=1 (for `D`≥2).
  - The first `o_tick` is in cycle `D` after enable.
- Period is exactly `D` cycles, with no gaps between periods.
- A divisor change is never visible mid-period. It applies at the edge ending the current period, or at the edge of the enable rising.
- `i_sync` truncates the current period; the next cycle is phase 0 on all active channels.
- Reset mid-operation: outputs are 0 in the cycle after the reset edge, and the divisor returns to `DEFAULT_DIV`.
- `o_clk` is a register output. Route it to the clock network only via a BUFG, or use `o_tick` as a clock enable.

## Structure
- Package `clk_div_pkg`:
  - `DIV_W` default.
  - `DEFAULT_DIV`.
  - Constant `MIN_DIV`=2.
  - Function `half_hi(D)`, which returns `D`−⌊`D`/2⌋.
- Sub-module `clk_div_channel`: one channel's state machine, counter, shadow register and outputs.
- Top level: a generate loop of `NUM_CH` instances, with `i_sync` and `i_div_wdata` fanned out to all.

## Test plan
- Reset and defaults:
  - After reset, all outputs are 0.
  - Enable ch0 → `o_clk[0]` is high 20 cycles and low 20 cycles.
  - `o_tick[0]` pulses every 40 cycles; the first pulse is 40 cycles after enable.
- Odd divisor:
  - Write 5 to ch1, then enable → `o_clk` pattern 1,1,1,0,0 repeating.
  - `o_tick` is high on the 5th cycle of each period.
- Boundary update, `D`=8:
  - Write 3 at `cnt`=2 → the current period completes at 8 cycles, then periods are 3 cycles.
  - Write 6 on the exact wrap edge → the next period is 6 cycles (bypass).
- Degenerate divisor:
  - Write 1 or 0 → `o_tick` is constantly 1 and `o_clk` is 0.
  - Then write 4 → the next edge begins 4-cycle periods.
- Sync and disable:
  - Channels at `D`=6 and `D`=10 running out of phase; pulse `i_sync` → both are at phase 0 the next cycle, with `o_clk`=1 on both.
  - Deassert `i_en[2]` mid-high → `o_clk[2]` is 0 the next cycle; re-enable starts a fresh full period.
- Reset mid-run:
  - Assert `i_rst` with a channel at `D`=7 mid-period → outputs are 0 the next cycle.
  - Re-enable → period is 40 (`DEFAULT_DIV`), not 7.
